vga_draw_arbiter: RTL and testbench

//  Parametrised successor to the hand-written draw mux: sequences N_SRC drawing engines
//  (map, link, enemies) onto the single VGA write port once per frame pass.

---
 rtl/vga_draw_pkg.sv | 25 ++
 rtl/vga_draw_arbiter_lowest_set_idx.sv | 23 ++
 rtl/vga_draw_arbiter.sv | 121 ++++++++++++
 tb/tb_vga_draw_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_draw_pkg.sv
// Shared constants for the VGA draw path: FSM encodings, default field widths
// and screen geometry used by the map and link_char engines.
package vga_draw_pkg;

  localparam int DEF_X_W      = 9;
  localparam int DEF_Y_W      = 8;
  localparam int DEF_COLOUR_W = 3;

  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;

  typedef logic [2:0] state_t;

  // Kept as plain constants so older tools that read this package still cope
  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_SCAN  = 3'd1;
  localparam state_t ST_GRANT = 3'd2;
  localparam state_t ST_GAP   = 3'd3;
  localparam state_t ST_FIN   = 3'd4;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vga_draw_arbiter_lowest_set_idx.sv
// Combinational priority encoder: reports whether any pending bit is set and
// the index of the lowest one, so source 0 (the map) is always drawn first.
module lowest_set_idx
  import vga_draw_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = idx_width(N)
) (
  input  logic [N-1:0]     pending,
  output logic             valid,
  output logic [IDX_W-1:0] index
);

  // Scan downwards so the last assignment wins with the lowest set bit
  always_comb begin
    valid = |pending;
    index = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pending[i]) index = IDX_W'(i);
    end
  end

endmodule

// File: rtl/vga_draw_arbiter.sv
// Sequences the drawing engines onto the single VGA write port once per frame
// pass, with a per-grant watchdog and a registered output stage.
module vga_draw_arbiter
  import vga_draw_pkg::*;
#(
  parameter int N_SRC            = 4,
  parameter int X_W              = DEF_X_W,
  parameter int Y_W              = DEF_Y_W,
  parameter int COLOUR_W         = DEF_COLOUR_W,
  parameter int MAX_GRANT_CYCLES = 98304,
  localparam int IDX_W           = idx_width(N_SRC),
  localparam int CNT_W           = $clog2(MAX_GRANT_CYCLES + 1)
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic                      frame_start,
  input  logic [N_SRC-1:0]          src_req,
  output logic [N_SRC-1:0]          src_go,
  input  logic [N_SRC*X_W-1:0]      src_x,
  input  logic [N_SRC*Y_W-1:0]      src_y,
  input  logic [N_SRC*COLOUR_W-1:0] src_colour,
  input  logic [N_SRC-1:0]          src_write,
  input  logic [N_SRC-1:0]          src_done,
  output logic [X_W-1:0]            vga_x,
  output logic [Y_W-1:0]            vga_y,
  output logic [COLOUR_W-1:0]       vga_colour,
  output logic                      vga_write,
  output logic [IDX_W-1:0]          active_src,
  output logic                      busy,
  output logic                      frame_done,
  output logic [N_SRC-1:0]          timeout_err,
  output logic                      overrun
);

  state_t           state;
  logic [N_SRC-1:0] pending;
  logic [CNT_W-1:0] cnt;
  logic             sel_valid;
  logic [IDX_W-1:0] sel_idx;
  logic             done_hit;
  logic             wdog_hit;

  lowest_set_idx #(
    .N     (N_SRC),
    .IDX_W (IDX_W)
  ) u_sel (
    .pending (pending),
    .valid   (sel_valid),
    .index   (sel_idx)
  );

  // A done still high from before the grant must not end it on cycle 0
  assign done_hit   = src_done[active_src] && (cnt != '0);
  assign wdog_hit   = (cnt == CNT_W'(MAX_GRANT_CYCLES - 1));
  assign busy       = (state != ST_IDLE);
  assign frame_done = (state == ST_FIN);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      pending     <= '0;
      cnt         <= '0;
      active_src  <= '0;
      src_go      <= '0;
      timeout_err <= '0;
      overrun     <= 1'b0;
    end else begin
      if (frame_start && (state != ST_IDLE)) overrun <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (frame_start) begin
            pending     <= src_req;
            timeout_err <= '0;
            overrun     <= 1'b0;
            state       <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (!sel_valid) begin
            state <= ST_FIN;
          end else begin
            active_src <= sel_idx;
            cnt        <= '0;
            src_go     <= N_SRC'(1) << sel_idx;
            state      <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          cnt <= cnt + CNT_W'(1);
          if (done_hit || wdog_hit) begin
            pending[active_src] <= 1'b0;
            src_go              <= '0;
            state               <= ST_GAP;
            if (!done_hit) timeout_err[active_src] <= 1'b1;
          end
        end
        ST_GAP:  state <= ST_SCAN;
        ST_FIN:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // One-cycle output stage; the pixel on a source's done cycle still goes out
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_write  <= 1'b0;
    end else if (state == ST_GRANT) begin
      vga_x      <= src_x[active_src*X_W +: X_W];
      vga_y      <= src_y[active_src*Y_W +: Y_W];
      vga_colour <= src_colour[active_src*COLOUR_W +: COLOUR_W];
      vga_write  <= src_write[active_src];
    end else begin
      vga_write  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_draw_arbiter.sv
// Scoreboard bench for vga_draw_arbiter: behavioural draw engines, directed
// frames with hand-timed expected pixels, grants and frame_done pulses.
module tb_vga_draw_arbiter;

  localparam int N    = 4;
  localparam int XW   = 9;
  localparam int YW   = 8;
  localparam int CW   = 3;
  localparam int MAXG = 8;

  logic             clock = 1'b0;
  logic             resetn = 1'b0;
  logic             frame_start = 1'b0;
  logic [N-1:0]     src_req = '0;
  logic [N-1:0]     src_go;
  logic [N*XW-1:0]  src_x = '0;
  logic [N*YW-1:0]  src_y = '0;
  logic [N*CW-1:0]  src_colour = '0;
  logic [N-1:0]     src_write = '0;
  logic [N-1:0]     src_done = '0;
  logic [XW-1:0]    vga_x;
  logic [YW-1:0]    vga_y;
  logic [CW-1:0]    vga_colour;
  logic             vga_write;
  logic [1:0]       active_src;
  logic             busy;
  logic             frame_done;
  logic [N-1:0]     timeout_err;
  logic             overrun;

  typedef struct {
    int            rel;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [CW-1:0] c;
  } pix_t;

  typedef struct {
    int rel;
    int idx;
  } go_t;

  pix_t pix_q[$];
  go_t  go_q[$];
  int   fd_q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int fs_cyc = 0;

  int npx[N];
  bit hang[N];
  bit early[N];
  int k[N];

  vga_draw_arbiter #(
    .N_SRC            (N),
    .X_W              (XW),
    .Y_W              (YW),
    .COLOUR_W         (CW),
    .MAX_GRANT_CYCLES (MAXG)
  ) dut (
    .clock       (clock),
    .resetn      (resetn),
    .frame_start (frame_start),
    .src_req     (src_req),
    .src_go      (src_go),
    .src_x       (src_x),
    .src_y       (src_y),
    .src_colour  (src_colour),
    .src_write   (src_write),
    .src_done    (src_done),
    .vga_x       (vga_x),
    .vga_y       (vga_y),
    .vga_colour  (vga_colour),
    .vga_write   (vga_write),
    .active_src  (active_src),
    .busy        (busy),
    .frame_done  (frame_done),
    .timeout_err (timeout_err),
    .overrun     (overrun)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc++;

  function automatic logic [XW-1:0] px_x(input int i, input int kk);
    return XW'(i * 16 + kk + 1);
  endfunction

  function automatic logic [YW-1:0] px_y(input int i, input int kk);
    return YW'(200 - i * 10 - kk);
  endfunction

  function automatic logic [CW-1:0] px_c(input int i, input int kk);
    return CW'((i + kk + 1) % 8);
  endfunction

  function automatic void check_output(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // Engine i draws npx pixels once granted, raising done with the last one
  initial begin
    forever begin
      @(negedge clock);
      for (int i = 0; i < N; i++) begin
        if (src_go[i]) begin
          src_write[i] = (k[i] < npx[i]);
          src_done[i]  = early[i] || (!hang[i] && (k[i] >= npx[i] - 1));
          src_x[i*XW +: XW]      = px_x(i, k[i]);
          src_y[i*YW +: YW]      = px_y(i, k[i]);
          src_colour[i*CW +: CW] = px_c(i, k[i]);
          k[i]++;
        end else begin
          k[i]         = 0;
          src_write[i] = 1'b0;
          src_done[i]  = early[i];
        end
      end
    end
  end

  // Monitor: every write, grant rise and frame_done must match the next expectation
  initial begin
    logic [N-1:0] prev_go;
    int rel;
    pix_t p;
    go_t g;
    int f;
    prev_go = '0;
    forever begin
      @(negedge clock);
      rel = cyc - fs_cyc;
      if (vga_write) begin
        if (pix_q.size() == 0) begin
          check_output("pix_extra", rel, -1);
        end else begin
          p = pix_q.pop_front();
          check_output("pix_rel", rel, p.rel);
          check_output("pix_x", vga_x, p.x);
          check_output("pix_y", vga_y, p.y);
          check_output("pix_colour", vga_colour, p.c);
        end
      end
      if ((src_go != prev_go) && (src_go != '0)) begin
        if (go_q.size() == 0) begin
          check_output("go_extra", src_go, 0);
        end else begin
          g = go_q.pop_front();
          check_output("go_rel", rel, g.rel);
          check_output("go_onehot", src_go, 1 << g.idx);
          check_output("active_src", active_src, g.idx);
        end
      end
      prev_go = src_go;
      if (frame_done) begin
        if (fd_q.size() == 0) begin
          check_output("fd_extra", rel, -1);
        end else begin
          f = fd_q.pop_front();
          check_output("fd_rel", rel, f);
        end
      end
    end
  end

  task automatic set_src(input int i, input int n, input bit h, input bit e);
    npx[i]   = n;
    hang[i]  = h;
    early[i] = e;
  endtask

  task automatic clear_srcs();
    for (int i = 0; i < N; i++) set_src(i, 0, 1'b0, 1'b0);
  endtask

  task automatic push_pix(input int i, input int first_rel, input int n);
    for (int kk = 0; kk < n; kk++)
      pix_q.push_back('{first_rel + kk, px_x(i, kk), px_y(i, kk), px_c(i, kk)});
  endtask

  task automatic push_go(input int rel, input int idx);
    go_q.push_back('{rel, idx});
  endtask

  task automatic apply_stimulus(input logic [N-1:0] req);
    @(negedge clock);
    src_req     = req;
    frame_start = 1'b1;
    fs_cyc      = cyc;
    @(negedge clock);
    frame_start = 1'b0;
  endtask

  task automatic pulse_frame_start();
    @(negedge clock);
    frame_start = 1'b1;
    @(negedge clock);
    frame_start = 1'b0;
  endtask

  task automatic wait_frame(input string name);
    int n;
    n = 0;
    while ((fd_q.size() != 0) && (n < 200)) begin
      @(negedge clock);
      n++;
    end
    check_output({name, "_fd_seen"}, fd_q.size(), 0);
    repeat (2) @(negedge clock);
    check_output({name, "_pix_left"}, pix_q.size(), 0);
    check_output({name, "_go_left"}, go_q.size(), 0);
    check_output({name, "_busy_end"}, busy, 0);
  endtask

  initial begin
    int n;
    clear_srcs();
    for (int i = 0; i < N; i++) k[i] = 0;

    resetn = 1'b0;
    repeat (3) @(negedge clock);
    check_output("rst_src_go", src_go, 0);
    check_output("rst_vga_write", vga_write, 0);
    check_output("rst_vga_x", vga_x, 0);
    check_output("rst_busy", busy, 0);
    check_output("rst_frame_done", frame_done, 0);
    check_output("rst_timeout", timeout_err, 0);
    check_output("rst_overrun", overrun, 0);
    check_output("rst_active", active_src, 0);
    resetn = 1'b1;
    repeat (2) @(negedge clock);

    // T1: two engines, 3 then 2 pixels
    clear_srcs();
    set_src(0, 3, 1'b0, 1'b0);
    set_src(1, 2, 1'b0, 1'b0);
    push_go(2, 0);
    push_pix(0, 3, 3);
    push_go(7, 1);
    push_pix(1, 8, 2);
    fd_q.push_back(11);
    apply_stimulus(4'b0011);
    check_output("t1_busy", busy, 1);
    wait_frame("t1");
    check_output("t1_timeout", timeout_err, 0);
    check_output("t1_overrun", overrun, 0);

    // T3: engine 1 hangs, watchdog moves on to engine 2
    clear_srcs();
    set_src(1, 2, 1'b1, 1'b0);
    set_src(2, 2, 1'b0, 1'b0);
    push_go(2, 1);
    push_pix(1, 3, 2);
    push_go(12, 2);
    push_pix(2, 13, 2);
    fd_q.push_back(16);
    apply_stimulus(4'b0110);
    wait_frame("t3");
    check_output("t3_timeout", timeout_err, 4'b0010);

    // T4: stale done from engine 0 before its grant
    clear_srcs();
    set_src(0, 2, 1'b0, 1'b1);
    repeat (2) @(negedge clock);
    push_go(2, 0);
    push_pix(0, 3, 2);
    fd_q.push_back(6);
    apply_stimulus(4'b0001);
    wait_frame("t4");
    check_output("t4_timeout_cleared", timeout_err, 0);
    early[0] = 1'b0;

    // T5: frame_start during a grant only flags overrun
    clear_srcs();
    set_src(0, 4, 1'b0, 1'b0);
    set_src(3, 2, 1'b0, 1'b0);
    push_go(2, 0);
    push_pix(0, 3, 4);
    push_go(8, 3);
    push_pix(3, 9, 2);
    fd_q.push_back(12);
    apply_stimulus(4'b1001);
    @(negedge clock);
    @(negedge clock);
    pulse_frame_start();
    wait_frame("t5");
    check_output("t5_overrun", overrun, 1);

    // T2: empty request set, also clears the overrun flag
    clear_srcs();
    fd_q.push_back(2);
    apply_stimulus(4'b0000);
    check_output("t2_overrun_cleared", overrun, 0);
    wait_frame("t2");

    // T6: reset asserted while engine 2 is drawing
    clear_srcs();
    set_src(2, 6, 1'b1, 1'b0);
    push_go(2, 2);
    push_pix(2, 3, 2);
    apply_stimulus(4'b0100);
    n = 0;
    while (((cyc - fs_cyc) < 4) && (n < 50)) begin
      @(negedge clock);
      n++;
    end
    check_output("t6_reach_grant", src_go, 4'b0100);
    @(posedge clock);
    #1 resetn = 1'b0;
    #1;
    check_output("t6_go_low", src_go, 0);
    check_output("t6_write_low", vga_write, 0);
    check_output("t6_busy_low", busy, 0);
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    repeat (5) @(negedge clock);
    check_output("t6_idle_busy", busy, 0);
    check_output("t6_idle_go", src_go, 0);
    check_output("t6_pix_left", pix_q.size(), 0);
    check_output("t6_go_left", go_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
